// File: rtl/riscv_core_rob_scoreboard.sv
// rtl/riscv_core_rob_scoreboard.sv - issue-side ROB scoreboard: RAW stall, writeback-port reservation, ROB fill
module riscv_core_rob_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_val,
   output logic       issue_rdy,
   input  logic       issue_rs1_en,
   input  logic [4:0] issue_rs1,
   input  logic       issue_rs2_en,
   input  logic [4:0] issue_rs2,
   input  logic       issue_rd_wen,
   input  logic [4:0] issue_rd,
   input  logic [1:0] issue_fu,
   output logic [3:0] issue_rob_slot,
   output logic       rob_alloc_req_val,
   input  logic       rob_alloc_req_rdy,
   output logic [4:0] rob_alloc_req_preg,
   input  logic [3:0] rob_alloc_resp_slot,
   output logic       rob_fill_val,
   output logic [3:0] rob_fill_slot,
   input  logic       rob_commit_wen,
   input  logic [3:0] rob_commit_slot,
   input  logic [4:0] rob_commit_rf_waddr
);

   // Register pending bits (bit 0 is never set) and newest in-flight writer per register.
   logic [31:0] pending;
   logic [3:0]  owner [32];

   // Writeback shift pipeline; position 1 is the completing instruction.
   logic [4:1]  wb_val;
   logic [3:0]  wb_slot [1:4];

   logic [2:0]  lat;
   logic        rs1_hit;
   logic        rs2_hit;
   logic        raw;
   logic        wbc;
   logic        fire;
   logic        rd_set;
   logic        commit_clr;

   // Functional-unit latency; encoding 3 behaves as an ALU.
   always_comb begin
      lat = 3'd1;
      case (issue_fu)
         2'd1:    lat = 3'd2;
         2'd2:    lat = 3'd4;
         default: lat = 3'd1;
      endcase
   end

   // Writeback-port conflict: the slot one position behind our landing spot would shift onto it.
   always_comb begin
      wbc = 1'b0;
      case (lat)
         3'd1:    wbc = wb_val[2];
         3'd2:    wbc = wb_val[3];
         default: wbc = 1'b0;
      endcase
   end

   // RAW check uses only registered pending state, so a commit this cycle is not forwarded.
   always_comb begin
      rs1_hit = issue_rs1_en && (issue_rs1 != 5'd0) && pending[issue_rs1];
      rs2_hit = issue_rs2_en && (issue_rs2 != 5'd0) && pending[issue_rs2];
      raw     = rs1_hit || rs2_hit;
   end

   // Handshake: the allocation request is independent of ROB readiness to avoid a comb loop.
   always_comb begin
      rob_alloc_req_val  = issue_val && !raw && !wbc;
      issue_rdy          = !raw && !wbc && rob_alloc_req_rdy;
      fire               = issue_val && issue_rdy;
      rob_alloc_req_preg = issue_rd_wen ? issue_rd : 5'd0;
      issue_rob_slot     = rob_alloc_resp_slot;
      rd_set             = fire && issue_rd_wen && (issue_rd != 5'd0);
      commit_clr         = rob_commit_wen && (rob_commit_rf_waddr != 5'd0)
                           && pending[rob_commit_rf_waddr]
                           && (owner[rob_commit_rf_waddr] == rob_commit_slot);
   end

   // Shift the writeback pipeline every cycle and drop a newly issued entry at its latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_val <= '0;
         for (int i = 1; i <= 4; i++) begin
            wb_slot[i] <= '0;
         end
      end else begin
         wb_val[1]  <= wb_val[2];
         wb_val[2]  <= wb_val[3];
         wb_val[3]  <= wb_val[4];
         wb_val[4]  <= 1'b0;
         wb_slot[1] <= wb_slot[2];
         wb_slot[2] <= wb_slot[3];
         wb_slot[3] <= wb_slot[4];
         wb_slot[4] <= 4'd0;
         if (fire) begin
            case (lat)
               3'd1: begin
                  wb_val[1]  <= 1'b1;
                  wb_slot[1] <= rob_alloc_resp_slot;
               end
               3'd2: begin
                  wb_val[2]  <= 1'b1;
                  wb_slot[2] <= rob_alloc_resp_slot;
               end
               default: begin
                  wb_val[4]  <= 1'b1;
                  wb_slot[4] <= rob_alloc_resp_slot;
               end
            endcase
         end
      end
   end

   // Pending/owner tracking; an issue to the same register overrides a same-cycle commit clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         for (int i = 0; i < 32; i++) begin
            owner[i] <= '0;
         end
      end else begin
         if (commit_clr) begin
            pending[rob_commit_rf_waddr] <= 1'b0;
         end
         if (rd_set) begin
            pending[issue_rd] <= 1'b1;
            owner[issue_rd]   <= rob_alloc_resp_slot;
         end
      end
   end

   assign rob_fill_val  = wb_val[1];
   assign rob_fill_slot = wb_slot[1];

endmodule

// File: tb/tb_riscv_core_rob_scoreboard.sv
// tb/tb_riscv_core_rob_scoreboard.sv - directed self-checking bench for riscv_core_rob_scoreboard
module tb_riscv_core_rob_scoreboard;

   logic       clk;
   logic       reset;
   logic       issue_val;
   logic       issue_rdy;
   logic       issue_rs1_en;
   logic [4:0] issue_rs1;
   logic       issue_rs2_en;
   logic [4:0] issue_rs2;
   logic       issue_rd_wen;
   logic [4:0] issue_rd;
   logic [1:0] issue_fu;
   logic [3:0] issue_rob_slot;
   logic       rob_alloc_req_val;
   logic       rob_alloc_req_rdy;
   logic [4:0] rob_alloc_req_preg;
   logic [3:0] rob_alloc_resp_slot;
   logic       rob_fill_val;
   logic [3:0] rob_fill_slot;
   logic       rob_commit_wen;
   logic [3:0] rob_commit_slot;
   logic [4:0] rob_commit_rf_waddr;

   int vectors;
   int miscompares;

   riscv_core_rob_scoreboard dut (
      .clk                 (clk),
      .reset               (reset),
      .issue_val           (issue_val),
      .issue_rdy           (issue_rdy),
      .issue_rs1_en        (issue_rs1_en),
      .issue_rs1           (issue_rs1),
      .issue_rs2_en        (issue_rs2_en),
      .issue_rs2           (issue_rs2),
      .issue_rd_wen        (issue_rd_wen),
      .issue_rd            (issue_rd),
      .issue_fu            (issue_fu),
      .issue_rob_slot      (issue_rob_slot),
      .rob_alloc_req_val   (rob_alloc_req_val),
      .rob_alloc_req_rdy   (rob_alloc_req_rdy),
      .rob_alloc_req_preg  (rob_alloc_req_preg),
      .rob_alloc_resp_slot (rob_alloc_resp_slot),
      .rob_fill_val        (rob_fill_val),
      .rob_fill_slot       (rob_fill_slot),
      .rob_commit_wen      (rob_commit_wen),
      .rob_commit_slot     (rob_commit_slot),
      .rob_commit_rf_waddr (rob_commit_rf_waddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_val           = 1'b0;
      issue_rs1_en        = 1'b0;
      issue_rs1           = 5'd0;
      issue_rs2_en        = 1'b0;
      issue_rs2           = 5'd0;
      issue_rd_wen        = 1'b0;
      issue_rd            = 5'd0;
      issue_fu            = 2'd0;
      rob_alloc_req_rdy   = 1'b1;
      rob_alloc_resp_slot = 4'd0;
      rob_commit_wen      = 1'b0;
      rob_commit_slot     = 4'd0;
      rob_commit_rf_waddr = 5'd0;
   endtask

   task automatic drive_issue(input logic [1:0] fu, input logic rd_wen, input logic [4:0] rd,
                              input logic [3:0] slot);
      issue_val           = 1'b1;
      issue_fu            = fu;
      issue_rd_wen        = rd_wen;
      issue_rd            = rd;
      rob_alloc_resp_slot = slot;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 5; i++) tick();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      #1;
      vectors++;
      if (rob_fill_val !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_fill_val got %0b want 0", rob_fill_val);
      end
      vectors++;
      if (rob_fill_slot !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_fill_slot got %0d want 0", rob_fill_slot);
      end
      vectors++;
      if (issue_rdy !== 1'b1 || rob_alloc_req_val !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_handshake got rdy=%0b req=%0b want rdy=1 req=0", issue_rdy, rob_alloc_req_val);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_alu_fill();
      idle();
      drive_issue(2'd0, 1'b1, 5'd5, 4'd0);
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_alloc_req_val !== 1'b1 || rob_alloc_req_preg !== 5'd5 || issue_rob_slot !== 4'd0) begin
         miscompares++;
         $display("FAIL alu_issue got rdy=%0b req=%0b preg=%0d slot=%0d want 1 1 5 0",
                  issue_rdy, rob_alloc_req_val, rob_alloc_req_preg, issue_rob_slot);
      end
      tick();
      idle();
      issue_val           = 1'b1;
      issue_rs1_en        = 1'b1;
      issue_rs1           = 5'd5;
      rob_alloc_resp_slot = 4'd1;
      rob_commit_wen      = 1'b1;
      rob_commit_slot     = 4'd0;
      rob_commit_rf_waddr = 5'd5;
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd0) begin
         miscompares++;
         $display("FAIL alu_fill got val=%0b slot=%0d want 1 0", rob_fill_val, rob_fill_slot);
      end
      vectors++;
      if (issue_rdy !== 1'b0 || rob_alloc_req_val !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_raw_commit_cycle got rdy=%0b req=%0b want 0 0", issue_rdy, rob_alloc_req_val);
      end
      tick();
      rob_commit_wen = 1'b0;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_fill_val !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_after_commit got rdy=%0b fill=%0b want 1 0", issue_rdy, rob_fill_val);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd1) begin
         miscompares++;
         $display("FAIL alu_dep_fill got val=%0b slot=%0d want 1 1", rob_fill_val, rob_fill_slot);
      end
      drain();
   endtask

   task automatic test_raw_mul();
      idle();
      drive_issue(2'd2, 1'b1, 5'd3, 4'd4);
      #1;
      vectors++;
      if (issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL mul_issue got rdy=%0b want 1", issue_rdy);
      end
      tick();
      for (int c = 1; c <= 5; c++) begin
         idle();
         issue_val           = 1'b1;
         issue_rs1_en        = 1'b1;
         issue_rs1           = 5'd3;
         rob_alloc_resp_slot = 4'd5;
         rob_commit_wen      = (c == 5);
         rob_commit_slot     = 4'd4;
         rob_commit_rf_waddr = 5'd3;
         #1;
         vectors++;
         if (issue_rdy !== 1'b0 || rob_alloc_req_val !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_raw_stall c%0d got rdy=%0b req=%0b want 0 0", c, issue_rdy, rob_alloc_req_val);
         end
         vectors++;
         if (rob_fill_val !== (c == 4) || (c == 4 && rob_fill_slot !== 4'd4)) begin
            miscompares++;
            $display("FAIL mul_fill c%0d got val=%0b slot=%0d want val=%0b slot=4", c, rob_fill_val, rob_fill_slot, (c == 4));
         end
         tick();
      end
      rob_commit_wen = 1'b0;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_alloc_req_val !== 1'b1) begin
         miscompares++;
         $display("FAIL mul_dep_release got rdy=%0b req=%0b want 1 1", issue_rdy, rob_alloc_req_val);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd5) begin
         miscompares++;
         $display("FAIL mul_dep_fill got val=%0b slot=%0d want 1 5", rob_fill_val, rob_fill_slot);
      end
      drain();
   endtask

   task automatic test_wbc();
      idle();
      drive_issue(2'd1, 1'b0, 5'd0, 4'd6);
      tick();
      drive_issue(2'd0, 1'b0, 5'd0, 4'd7);
      #1;
      vectors++;
      if (issue_rdy !== 1'b0 || rob_alloc_req_val !== 1'b0 || rob_fill_val !== 1'b0) begin
         miscompares++;
         $display("FAIL wbc_stall got rdy=%0b req=%0b fill=%0b want 0 0 0", issue_rdy, rob_alloc_req_val, rob_fill_val);
      end
      tick();
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd6) begin
         miscompares++;
         $display("FAIL wbc_release got rdy=%0b fill=%0b slot=%0d want 1 1 6", issue_rdy, rob_fill_val, rob_fill_slot);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd7) begin
         miscompares++;
         $display("FAIL wbc_second_fill got val=%0b slot=%0d want 1 7", rob_fill_val, rob_fill_slot);
      end
      tick();
      vectors++;
      if (rob_fill_val !== 1'b0) begin
         miscompares++;
         $display("FAIL wbc_drain got val=%0b want 0", rob_fill_val);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      idle();
      for (int c = 0; c < 3; c++) begin
         drive_issue(2'd0, 1'b0, 5'd0, 4'(8 + c));
         #1;
         vectors++;
         if (issue_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_rdy c%0d got %0b want 1", c, issue_rdy);
         end
         if (c > 0) begin
            vectors++;
            if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'(7 + c)) begin
               miscompares++;
               $display("FAIL b2b_fill c%0d got val=%0b slot=%0d want 1 %0d", c, rob_fill_val, rob_fill_slot, 7 + c);
            end
         end
         tick();
      end
      idle();
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd10) begin
         miscompares++;
         $display("FAIL b2b_last_fill got val=%0b slot=%0d want 1 10", rob_fill_val, rob_fill_slot);
      end
      drain();
      drive_issue(2'd2, 1'b0, 5'd0, 4'd1);
      tick();
      tick();
      tick();
      drive_issue(2'd0, 1'b0, 5'd0, 4'd2);
      #1;
      vectors++;
      if (issue_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_mul_alu_wbc got rdy=%0b want 0", issue_rdy);
      end
      drain();
   endtask

   task automatic test_waw();
      idle();
      drive_issue(2'd0, 1'b1, 5'd7, 4'd2);
      tick();
      drive_issue(2'd0, 1'b1, 5'd7, 4'd3);
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_fill_slot !== 4'd2 || rob_fill_val !== 1'b1) begin
         miscompares++;
         $display("FAIL waw_second_issue got rdy=%0b fill=%0b slot=%0d want 1 1 2", issue_rdy, rob_fill_val, rob_fill_slot);
      end
      tick();
      idle();
      issue_val           = 1'b1;
      issue_rs1_en        = 1'b1;
      issue_rs1           = 5'd7;
      rob_commit_wen      = 1'b1;
      rob_commit_slot     = 4'd2;
      rob_commit_rf_waddr = 5'd7;
      #1;
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd3) begin
         miscompares++;
         $display("FAIL waw_fill_3 got val=%0b slot=%0d want 1 3", rob_fill_val, rob_fill_slot);
      end
      tick();
      rob_commit_slot = 4'd3;
      #1;
      vectors++;
      if (issue_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL waw_stale_commit got rdy=%0b want 0", issue_rdy);
      end
      tick();
      rob_commit_wen = 1'b0;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL waw_owner_commit got rdy=%0b want 1", issue_rdy);
      end
      drain();
   endtask

   task automatic test_same_cycle();
      idle();
      drive_issue(2'd0, 1'b1, 5'd9, 4'd11);
      tick();
      drive_issue(2'd0, 1'b1, 5'd9, 4'd12);
      rob_commit_wen      = 1'b1;
      rob_commit_slot     = 4'd11;
      rob_commit_rf_waddr = 5'd9;
      tick();
      idle();
      issue_val           = 1'b1;
      issue_rs2_en        = 1'b1;
      issue_rs2           = 5'd9;
      issue_rd_wen        = 1'b1;
      issue_rd            = 5'd9;
      rob_commit_wen      = 1'b1;
      rob_commit_slot     = 4'd12;
      rob_commit_rf_waddr = 5'd9;
      #1;
      vectors++;
      if (issue_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_issue_wins got rdy=%0b want 0", issue_rdy);
      end
      tick();
      rob_commit_wen = 1'b0;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL same_cycle_release got rdy=%0b want 1", issue_rdy);
      end
      drain();
   endtask

   task automatic test_alloc_not_ready();
      idle();
      drive_issue(2'd0, 1'b1, 5'd12, 4'd13);
      rob_alloc_req_rdy = 1'b0;
      #1;
      vectors++;
      if (rob_alloc_req_val !== 1'b1 || issue_rdy !== 1'b0 || rob_alloc_req_preg !== 5'd12) begin
         miscompares++;
         $display("FAIL alloc_nrdy got req=%0b rdy=%0b preg=%0d want 1 0 12", rob_alloc_req_val, issue_rdy, rob_alloc_req_preg);
      end
      tick();
      idle();
      issue_val    = 1'b1;
      issue_rs1_en = 1'b1;
      issue_rs1    = 5'd12;
      #1;
      vectors++;
      if (rob_fill_val !== 1'b0 || issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL alloc_nrdy_no_state got fill=%0b rdy=%0b want 0 1", rob_fill_val, issue_rdy);
      end
      drain();
   endtask

   task automatic test_zero_regs();
      idle();
      drive_issue(2'd3, 1'b1, 5'd0, 4'd14);
      #1;
      vectors++;
      if (rob_alloc_req_preg !== 5'd0 || issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_rd got preg=%0d rdy=%0b want 0 1", rob_alloc_req_preg, issue_rdy);
      end
      tick();
      idle();
      issue_val    = 1'b1;
      issue_rs1_en = 1'b1;
      issue_rs2_en = 1'b1;
      issue_fu     = 2'd2;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1 || rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd14) begin
         miscompares++;
         $display("FAIL zero_rs got rdy=%0b fill=%0b slot=%0d want 1 1 14", issue_rdy, rob_fill_val, rob_fill_slot);
      end
      drain();
   endtask

   task automatic test_reset_inflight();
      idle();
      drive_issue(2'd2, 1'b1, 5'd4, 4'd15);
      tick();
      idle();
      tick();
      tick();
      tick();
      vectors++;
      if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd15) begin
         miscompares++;
         $display("FAIL rst_pre_fill got val=%0b slot=%0d want 1 15", rob_fill_val, rob_fill_slot);
      end
      reset               = 1'b1;
      rob_commit_wen      = 1'b1;
      rob_commit_slot     = 4'd15;
      rob_commit_rf_waddr = 5'd4;
      #1;
      vectors++;
      if (rob_fill_val !== 1'b0 || rob_fill_slot !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_inflight got val=%0b slot=%0d want 0 0", rob_fill_val, rob_fill_slot);
      end
      tick();
      reset = 1'b0;
      idle();
      issue_val    = 1'b1;
      issue_rs1_en = 1'b1;
      issue_rs1    = 5'd4;
      #1;
      vectors++;
      if (issue_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pending_cleared got rdy=%0b want 1", issue_rdy);
      end
      issue_val = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (rob_fill_val !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pipe_empty c%0d got val=%0b want 0", c, rob_fill_val);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      idle();
      test_reset();
      test_alu_fill();
      test_raw_mul();
      test_wbc();
      test_back_to_back();
      test_waw();
      test_same_cycle();
      test_alloc_not_ready();
      test_zero_regs();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_core_rob_scoreboard.md
# riscv_core_rob_scoreboard

Issue-side companion to the core's 16-entry reorder buffer (ROB). It sits between decode/issue and the functional units. For each issued instruction it does four things:
- requests a ROB slot;
- tracks per-architectural-register pending state to stall RAW hazards;
- tracks in-flight instructions through a fixed-latency writeback shift pipeline, stalling on writeback-port conflicts;
- drives the ROB fill port when each instruction completes.

ROB commits clear register pending state.

## Interface
- No parameters. ROB depth is fixed at 16 (4-bit slot). Maximum functional-unit latency is fixed at 4.
- clk  in  1  core clock. All state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_val  in  1  decode presents an instruction.
- issue_rdy  out  1  instruction accepted this cycle when issue_val && issue_rdy.
- issue_rs1_en  in  1  instruction reads rs1.
- issue_rs1  in  5  rs1 index.
- issue_rs2_en  in  1  instruction reads rs2.
- issue_rs2  in  5  rs2 index.
- issue_rd_wen  in  1  instruction writes rd.
- issue_rd  in  5  rd index.
- issue_fu  in  2  unit select: 0 ALU (latency 1), 1 MEM (latency 2), 2 MUL (latency 4), 3 treated as ALU (latency 1).
- issue_rob_slot  out  4  ROB slot assigned to the issuing instruction; equals rob_alloc_resp_slot.
- rob_alloc_req_val  out  1  ROB allocation request.
- rob_alloc_req_rdy  in  1  ROB has a free tail entry.
- rob_alloc_req_preg  out  5  destination for commit: issue_rd if issue_rd_wen, else 0.
- rob_alloc_resp_slot  in  4  ROB tail slot, valid with rob_alloc_req_rdy.
- rob_fill_val  out  1  an instruction completes writeback this cycle.
- rob_fill_slot  out  4  its ROB slot.
- rob_commit_wen  in  1  ROB commits its head this cycle.
- rob_commit_slot  in  4  committed slot.
- rob_commit_rf_waddr  in  5  committed destination register.

## Operation
State:
- pending[31:0], with x0 never pending.
- owner[r]: 4-bit ROB slot of the newest in-flight writer of r.
- wb_pipe positions 1..4, each holding {val, slot}.

Hazards (combinational on current state):
- raw = (rs1_en && rs1!=0 && pending[rs1]) || (rs2_en && rs2!=0 && pending[rs2]).
- wbc = (L<4) && wb_pipe[L+1].val, where L is the latency of issue_fu.

Handshake:
- rob_alloc_req_val = issue_val && !raw && !wbc. It does not depend on rob_alloc_req_rdy.
- issue_rdy = !raw && !wbc && rob_alloc_req_rdy.
- fire = issue_val && issue_rdy.

On fire:
- wb_pipe[L] <= {1, rob_alloc_resp_slot}.
- If issue_rd_wen && rd!=0: pending[rd] <= 1 and owner[rd] <= rob_alloc_resp_slot.

Every edge:
- wb_pipe[k] <= wb_pipe[k+1] for k=1..3.
- wb_pipe[4] <= 0 unless filled by the fire above.
- Position 1 is consumed. Outputs: rob_fill_val = wb_pipe[1].val, rob_fill_slot = wb_pipe[1].slot.

Commit:
- If rob_commit_wen && waddr!=0 && pending[waddr] && owner[waddr]==rob_commit_slot: pending[waddr] <= 0.
- A stale commit from an older writer (WAW, owner mismatch) leaves pending set.

Simultaneous events:
- Issue set and commit clear on the same register in the same cycle: the issue wins (pending=1, new owner).
- No same-cycle forwarding of a commit into the raw check; the register becomes readable the following cycle.
- rs == rd within one instruction checks the old pending state.

Reset: pending and owner are cleared, wb_pipe is emptied, and commits are ignored while reset is asserted.

## Timing
- Reset values: rob_fill_val=0, rob_fill_slot=0. issue_rdy, rob_alloc_req_val, rob_alloc_req_preg and issue_rob_slot are combinational from inputs and the reset state.
- Issue accepted at edge t with latency L → rob_fill_val asserted during cycle t+L, for exactly one cycle.
- At most one fill per cycle, guaranteed by wbc.
- Back-to-back issue is possible every cycle when there are no hazards.
- Dependent instruction: earliest issue is the cycle after the producer's commit cycle.

## Test plan
- Reset, then ALU rd=5 issue with slot 0 → fill_val=1, slot=0 one cycle later. pending[5]=1 until commit(slot 0, waddr 5), cleared the next cycle.
- MUL rd=3 at cycle 0, then ALU rs1=3 → issue_rdy=0 until the cycle after commit of rd=3. rob_alloc_req_val=0 throughout.
- MEM at cycle 0, then ALU at cycle 1 → wbc holds the ALU off one cycle. Fills occur in cycles 2 and 3, never in the same cycle.
- WAW: ALU rd=7 slot 2, then ALU rd=7 slot 3. Commit slot 2 → pending[7] stays 1. Commit slot 3 → cleared.
- rob_alloc_req_rdy=0 with issue_val=1 and no hazards → rob_alloc_req_val=1, issue_rdy=0, no state change.
- rd=0 writes and rs=0 reads never stall. Asserting reset with MUL in flight → fill_val=0 immediately and pipe empty.
